// File: rtl/swap_pkg.sv
// Shared types and default widths for the swap controller and its helpers.
package swap_pkg;

    localparam int SWAP_LOG_N_INIT = 2;
    localparam int SWAP_LEASE_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_REVERT  = 2'd3
    } swap_state_e;

    typedef struct packed {
        logic                       sel;
        logic [SWAP_LOG_N_INIT-1:0] source;
        logic [SWAP_LOG_N_INIT-1:0] target;
    } swap_entry_t;

endpackage

// File: rtl/swap_lease_timer.sv
// Loadable down-counter that flags the last cycle of a running lease.
// A load value of 0 leaves the counter parked at 0, so it never expires.
module swap_lease_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expire
);

    logic [W-1:0] count;

    // Load takes priority; otherwise count down while enabled and not yet at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expire = en && !load && (count == W'(1));

endmodule

// File: rtl/swap_ctrl.sv
// Swap controller: shadow bank written by software, applied atomically to the
// active bank only while the interconnect is idle, with optional lease revert.
module swap_ctrl
    import swap_pkg::*;
#(
    parameter int N_INIT_PORT = 8,
    parameter int LOG_N_INIT  = SWAP_LOG_N_INIT,
    parameter int PORT_W      = $clog2(N_INIT_PORT),
    parameter int LEASE_W     = SWAP_LEASE_W
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   cfg_valid_i,
    output logic                                   cfg_ready_o,
    input  logic [PORT_W-1:0]                      cfg_port_i,
    input  logic                                   cfg_sel_i,
    input  logic [LOG_N_INIT-1:0]                  cfg_source_i,
    input  logic [LOG_N_INIT-1:0]                  cfg_target_i,
    input  logic                                   commit_i,
    input  logic                                   revert_i,
    input  logic [LEASE_W-1:0]                     lease_i,
    input  logic                                   idle_i,
    output logic [N_INIT_PORT-1:0]                 select_o,
    output logic [N_INIT_PORT-1:0][LOG_N_INIT-1:0] source_o,
    output logic [N_INIT_PORT-1:0][LOG_N_INIT-1:0] target_o,
    output logic                                   swap_active_o,
    output logic                                   busy_o
);

    swap_state_e        state;
    swap_state_e        state_next;
    swap_entry_t        shadow [N_INIT_PORT];
    logic [LEASE_W-1:0] lease_q;
    logic               wr_accept;
    logic               take_commit;
    logic               apply;
    logic               clear;
    logic               expire;

    assign wr_accept   = cfg_valid_i && cfg_ready_o;
    assign take_commit = commit_i && ((state == ST_IDLE) || (state == ST_ACTIVE));

    // Next-state decision; a commit in ACTIVE outranks both revert and lease expiry.
    always_comb begin
        state_next = state;
        apply      = 1'b0;
        clear      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (commit_i) state_next = ST_PENDING;
            end
            ST_PENDING: begin
                if (idle_i) begin
                    state_next = ST_ACTIVE;
                    apply      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (commit_i) begin
                    state_next = ST_PENDING;
                end else if (revert_i || expire) begin
                    state_next = ST_REVERT;
                end
            end
            ST_REVERT: begin
                if (idle_i) begin
                    state_next = ST_IDLE;
                    clear      = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register, registered status flags, lease latch and the active bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            lease_q       <= '0;
            select_o      <= '0;
            source_o      <= '0;
            target_o      <= '0;
            swap_active_o <= 1'b0;
            busy_o        <= 1'b0;
            cfg_ready_o   <= 1'b1;
        end else begin
            state         <= state_next;
            swap_active_o <= (state_next == ST_ACTIVE);
            busy_o        <= (state_next == ST_PENDING) || (state_next == ST_REVERT);
            cfg_ready_o   <= (state_next == ST_IDLE) || (state_next == ST_ACTIVE);
            if (take_commit) begin
                lease_q <= lease_i;
            end
            if (apply) begin
                for (int i = 0; i < N_INIT_PORT; i++) begin
                    select_o[i] <= shadow[i].sel;
                    source_o[i] <= shadow[i].source;
                    target_o[i] <= shadow[i].target;
                end
            end else if (clear) begin
                select_o <= '0;
                source_o <= '0;
                target_o <= '0;
            end
        end
    end

    // Shadow write decode; out-of-range indices match no entry and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_INIT_PORT; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_INIT_PORT; i++) begin
                if (wr_accept && (cfg_port_i == PORT_W'(i))) begin
                    shadow[i].sel    <= cfg_sel_i;
                    shadow[i].source <= cfg_source_i;
                    shadow[i].target <= cfg_target_i;
                end
            end
        end
    end

    swap_lease_timer #(
        .W (LEASE_W)
    ) u_lease_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (apply),
        .load_val (lease_q),
        .en       (state == ST_ACTIVE),
        .expire   (expire)
    );

endmodule

// File: tb/tb_swap_ctrl.sv
// Self-checking bench for swap_ctrl: a shadow-bank model pushes the expected
// active bank on every commit, popped and compared when the apply lands.
module tb_swap_ctrl;

    localparam int NP = 8;
    localparam int LN = 2;
    localparam int PW = 4;
    localparam int LW = 16;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   cfg_valid_i = 1'b0;
    logic                   cfg_ready_o;
    logic [PW-1:0]          cfg_port_i = '0;
    logic                   cfg_sel_i = 1'b0;
    logic [LN-1:0]          cfg_source_i = '0;
    logic [LN-1:0]          cfg_target_i = '0;
    logic                   commit_i = 1'b0;
    logic                   revert_i = 1'b0;
    logic [LW-1:0]          lease_i = '0;
    logic                   idle_i = 1'b1;
    logic [NP-1:0]          select_o;
    logic [NP-1:0][LN-1:0]  source_o;
    logic [NP-1:0][LN-1:0]  target_o;
    logic                   swap_active_o;
    logic                   busy_o;

    typedef struct packed {
        logic [NP-1:0]         sel;
        logic [NP-1:0][LN-1:0] src;
        logic [NP-1:0][LN-1:0] tgt;
    } bank_t;

    bank_t shadow_m = '0;
    bank_t cur      = '0;
    bank_t e;
    bank_t exp_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    swap_ctrl #(
        .N_INIT_PORT (NP),
        .LOG_N_INIT  (LN),
        .PORT_W      (PW),
        .LEASE_W     (LW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_valid_i   (cfg_valid_i),
        .cfg_ready_o   (cfg_ready_o),
        .cfg_port_i    (cfg_port_i),
        .cfg_sel_i     (cfg_sel_i),
        .cfg_source_i  (cfg_source_i),
        .cfg_target_i  (cfg_target_i),
        .commit_i      (commit_i),
        .revert_i      (revert_i),
        .lease_i       (lease_i),
        .idle_i        (idle_i),
        .select_o      (select_o),
        .source_o      (source_o),
        .target_o      (target_o),
        .swap_active_o (swap_active_o),
        .busy_o        (busy_o)
    );

    function automatic bank_t dut_bank();
        return bank_t'({select_o, source_o, target_o});
    endfunction

    // One clock of stimulus; the model tracks writes and queues a snapshot on commit.
    task automatic drive_cycle(input logic v, input logic [PW-1:0] p, input logic s,
                               input logic [LN-1:0] sr, input logic [LN-1:0] tg,
                               input logic cm, input logic rv, input logic [LW-1:0] ls,
                               input logic idl);
        cfg_valid_i  = v;
        cfg_port_i   = p;
        cfg_sel_i    = s;
        cfg_source_i = sr;
        cfg_target_i = tg;
        commit_i     = cm;
        revert_i     = rv;
        lease_i      = ls;
        idle_i       = idl;
        if (v && (p < PW'(NP))) begin
            shadow_m.sel[p[2:0]] = s;
            shadow_m.src[p[2:0]] = sr;
            shadow_m.tgt[p[2:0]] = tg;
        end
        if (cm) exp_q.push_back(shadow_m);
        @(posedge clk);
        #1;
        cfg_valid_i = 1'b0;
        commit_i    = 1'b0;
        revert_i    = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input logic idl);
        for (int k = 0; k < n; k++) begin
            drive_cycle(1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 16'd0, idl);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (select_o !== '0) begin n_fail++; $display("FAIL reset_select: actual %h required 0", select_o); end
        n_cmp++;
        if (source_o !== '0) begin n_fail++; $display("FAIL reset_source: actual %h required 0", source_o); end
        n_cmp++;
        if (target_o !== '0) begin n_fail++; $display("FAIL reset_target: actual %h required 0", target_o); end
        n_cmp++;
        if (swap_active_o !== 1'b0) begin n_fail++; $display("FAIL reset_active: actual %b required 0", swap_active_o); end
        n_cmp++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: actual %b required 0", busy_o); end
        n_cmp++;
        if (cfg_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: actual %b required 1", cfg_ready_o); end
    endtask

    task automatic test_basic_commit();
        int drops;
        drive_cycle(1'b1, 4'd3, 1'b1, 2'd2, 2'd1, 1'b0, 1'b0, 16'd0, 1'b1);
        n_cmp++;
        if (dut_bank() !== cur) begin n_fail++; $display("FAIL basic_write_no_effect: actual %h required %h", dut_bank(), cur); end
        drive_cycle(1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 16'd0, 1'b1);
        n_cmp++;
        if (busy_o !== 1'b1 || dut_bank() !== cur) begin
            n_fail++; $display("FAIL basic_pending: actual busy=%b bank=%h required busy=1 bank=%h", busy_o, dut_bank(), cur);
        end
        idle_cycles(1, 1'b1);
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL basic_apply: actual %h required <scoreboard entry, queue empty>", dut_bank());
        end else begin
            e = exp_q.pop_front();
            cur = e;
            if (dut_bank() !== e) begin n_fail++; $display("FAIL basic_apply: actual %h required %h", dut_bank(), e); end
        end
        n_cmp++;
        if (select_o !== 8'h08 || source_o[3] !== 2'd2 || target_o[3] !== 2'd1 || swap_active_o !== 1'b1) begin
            n_fail++; $display("FAIL basic_port3: actual sel=%h src3=%0d tgt3=%0d act=%b required sel=08 src3=2 tgt3=1 act=1",
                               select_o, source_o[3], target_o[3], swap_active_o);
        end
        drops = 0;
        for (int k = 0; k < 1000; k++) begin
            idle_cycles(1, 1'b1);
            if (swap_active_o !== 1'b1 || dut_bank() !== cur) drops++;
        end
        n_cmp++;
        if (drops != 0) begin n_fail++; $display("FAIL basic_permanent: actual %0d inactive cycles required 0", drops); end
    endtask

    task automatic test_quiescence();
        drive_cycle(1'b1, 4'd1, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0, 16'd0, 1'b0);
        drive_cycle(1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 16'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            idle_cycles(1, 1'b0);
            n_cmp++;
            if (dut_bank() !== cur || busy_o !== 1'b1 || cfg_ready_o !== 1'b0) begin
                n_fail++; $display("FAIL quiesce_hold[%0d]: actual bank=%h busy=%b ready=%b required bank=%h busy=1 ready=0",
                                   k, dut_bank(), busy_o, cfg_ready_o, cur);
            end
        end
        idle_cycles(1, 1'b1);
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL quiesce_apply: actual %h required <scoreboard entry, queue empty>", dut_bank());
        end else begin
            e = exp_q.pop_front();
            cur = e;
            if (dut_bank() !== e || swap_active_o !== 1'b1) begin
                n_fail++; $display("FAIL quiesce_apply: actual %h act=%b required %h act=1", dut_bank(), swap_active_o, e);
            end
        end
    endtask

    task automatic test_lease();
        int hi;
        drive_cycle(1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 16'd4, 1'b1);
        idle_cycles(1, 1'b1);
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL lease_apply: actual %h required <scoreboard entry, queue empty>", dut_bank());
        end else begin
            e = exp_q.pop_front();
            cur = e;
            if (dut_bank() !== e) begin n_fail++; $display("FAIL lease_apply: actual %h required %h", dut_bank(), e); end
        end
        hi = (swap_active_o === 1'b1) ? 1 : 0;
        for (int k = 0; k < 20 && hi > 0; k++) begin
            idle_cycles(1, 1'b1);
            if (swap_active_o === 1'b1) hi++;
            else break;
        end
        n_cmp++;
        if (hi != 4) begin n_fail++; $display("FAIL lease_length: actual %0d active cycles required 4", hi); end
        n_cmp++;
        if (busy_o !== 1'b1 || dut_bank() !== cur) begin
            n_fail++; $display("FAIL lease_revert_hold: actual busy=%b bank=%h required busy=1 bank=%h", busy_o, dut_bank(), cur);
        end
        idle_cycles(1, 1'b1);
        cur = '0;
        n_cmp++;
        if (dut_bank() !== cur || busy_o !== 1'b0 || cfg_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL lease_cleared: actual bank=%h busy=%b ready=%b required bank=0 busy=0 ready=1",
                               dut_bank(), busy_o, cfg_ready_o);
        end
        drive_cycle(1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 16'd0, 1'b1);
        idle_cycles(1, 1'b1);
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL lease_retained: actual %h required <scoreboard entry, queue empty>", dut_bank());
        end else begin
            e = exp_q.pop_front();
            cur = e;
            if (dut_bank() !== e) begin n_fail++; $display("FAIL lease_retained: actual %h required %h", dut_bank(), e); end
        end
    endtask

    task automatic test_simultaneous();
        drive_cycle(1'b1, 4'd6, 1'b1, 2'd1, 2'd3, 1'b0, 1'b0, 16'd0, 1'b1);
        n_cmp++;
        if (dut_bank() !== cur) begin n_fail++; $display("FAIL simul_write_no_effect: actual %h required %h", dut_bank(), cur); end
        drive_cycle(1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 16'd0, 1'b1);
        n_cmp++;
        if (busy_o !== 1'b1 || swap_active_o !== 1'b0) begin
            n_fail++; $display("FAIL simul_commit_revert_state: actual busy=%b act=%b required busy=1 act=0", busy_o, swap_active_o);
        end
        idle_cycles(1, 1'b1);
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL simul_commit_wins: actual %h required <scoreboard entry, queue empty>", dut_bank());
        end else begin
            e = exp_q.pop_front();
            cur = e;
            if (dut_bank() !== e) begin n_fail++; $display("FAIL simul_commit_wins: actual %h required %h", dut_bank(), e); end
        end
        drive_cycle(1'b1, 4'd5, 1'b1, 2'd3, 2'd2, 1'b1, 1'b0, 16'd0, 1'b1);
        idle_cycles(1, 1'b1);
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL simul_write_commit: actual %h required <scoreboard entry, queue empty>", dut_bank());
        end else begin
            e = exp_q.pop_front();
            cur = e;
            if (dut_bank() !== e) begin n_fail++; $display("FAIL simul_write_commit: actual %h required %h", dut_bank(), e); end
        end
        n_cmp++;
        if (select_o[5] !== 1'b1) begin n_fail++; $display("FAIL simul_port5_sel: actual %b required 1", select_o[5]); end
    endtask

    task automatic test_reset_bad_index();
        drive_cycle(1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 16'd0, 1'b0);
        n_cmp++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL midreset_pending: actual busy=%b required 1", busy_o); end
        rst_n = 1'b0;
        #2;
        shadow_m = '0;
        cur      = '0;
        exp_q.delete();
        n_cmp++;
        if (dut_bank() !== cur || swap_active_o !== 1'b0 || busy_o !== 1'b0 || cfg_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL midreset_async: actual bank=%h act=%b busy=%b ready=%b required bank=0 act=0 busy=0 ready=1",
                               dut_bank(), swap_active_o, busy_o, cfg_ready_o);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive_cycle(1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 16'd0, 1'b1);
        idle_cycles(1, 1'b1);
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL midreset_zero_bank: actual %h required <scoreboard entry, queue empty>", dut_bank());
        end else begin
            e = exp_q.pop_front();
            cur = e;
            if (dut_bank() !== e || swap_active_o !== 1'b1) begin
                n_fail++; $display("FAIL midreset_zero_bank: actual %h act=%b required %h act=1", dut_bank(), swap_active_o, e);
            end
        end
        drive_cycle(1'b1, 4'd9, 1'b1, 2'd3, 2'd3, 1'b0, 1'b0, 16'd0, 1'b1);
        drive_cycle(1'b0, 4'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 16'd0, 1'b1);
        idle_cycles(1, 1'b1);
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL bad_index: actual %h required <scoreboard entry, queue empty>", dut_bank());
        end else begin
            e = exp_q.pop_front();
            cur = e;
            if (dut_bank() !== e) begin n_fail++; $display("FAIL bad_index: actual %h required %h", dut_bank(), e); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_commit();
        test_quiescence();
        test_lease();
        test_simultaneous();
        test_reset_bad_index();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: actual %0d entries left required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
